// File: rtl/ddr_bank_timing_tracker.sv
// ddr_bank_timing_tracker: per-bank DDR state machines and timing
// counters that publish which commands are legal this cycle.
// Ports: clk, rst_n (async, low), cmd_valid/cmd/cmd_bank/cmd_row in;
// act_ok/rdwr_ok/pre_ok/ref_ok flags, bank_open/open_row table and
// cmd_err (registered illegal-command pulse) out.
// Optional: define DDR_TRACK_FAW_EN for the four-activate window.
module ddr_bank_timing_tracker #(
  parameter int NUM_BANKS = 8,
  parameter int ROW_W     = 14,
  parameter int CNT_W     = 8,
  parameter int T_RCD     = 15,
  parameter int T_RP      = 15,
  parameter int T_RAS     = 40,
  parameter int T_RC      = 55,
  parameter int T_RRD     = 10,
  parameter int T_WR      = 15,
  parameter int T_RTP     = 7,
  parameter int T_RFC     = 105,
  parameter int T_FAW     = 45
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  input  logic [3:0]                   cmd,
  input  logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
  input  logic [ROW_W-1:0]             cmd_row,
  output logic [NUM_BANKS-1:0]         act_ok,
  output logic [NUM_BANKS-1:0]         rdwr_ok,
  output logic [NUM_BANKS-1:0]         pre_ok,
  output logic                         ref_ok,
  output logic [NUM_BANKS-1:0]         bank_open,
  output logic [NUM_BANKS*ROW_W-1:0]   open_row,
  output logic                         cmd_err
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int T_MAX  = 2**CNT_W - 1;

  if (T_RCD > T_MAX || T_RP  > T_MAX ||
      T_RAS > T_MAX || T_RC  > T_MAX ||
      T_RRD > T_MAX || T_WR  > T_MAX ||
      T_RTP > T_MAX || T_RFC > T_MAX ||
      T_FAW > T_MAX ||
      T_RCD < 1 || T_RP  < 1 ||
      T_RAS < 1 || T_RC  < 1 ||
      T_RRD < 1 || T_WR  < 1 ||
      T_RTP < 1 || T_RFC < 1 ||
      T_FAW < 1) begin : g_bad_timing
    $error("timing parameter out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] L_RCD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] L_RP  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] L_RAS = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] L_RC  = CNT_W'(T_RC - 1);
  localparam logic [CNT_W-1:0] L_RRD = CNT_W'(T_RRD - 1);
  localparam logic [CNT_W-1:0] L_WR  = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] L_RTP = CNT_W'(T_RTP - 1);
  localparam logic [CNT_W-1:0] L_RFC = CNT_W'(T_RFC - 1);

  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTG,
    S_ACTV,
    S_PRCH
  } bank_st_e;

  bank_st_e st_q [NUM_BANKS];
  bank_st_e st_d [NUM_BANKS];

  logic [CNT_W-1:0] rcd_q [NUM_BANKS];
  logic [CNT_W-1:0] rp_q  [NUM_BANKS];
  logic [CNT_W-1:0] ras_q [NUM_BANKS];
  logic [CNT_W-1:0] rc_q  [NUM_BANKS];
  logic [CNT_W-1:0] wr_q  [NUM_BANKS];
  logic [CNT_W-1:0] rtp_q [NUM_BANKS];
  logic [CNT_W-1:0] rrd_q;
  logic [CNT_W-1:0] rfc_q;

  logic [ROW_W-1:0]     row_q [NUM_BANKS];
  logic [NUM_BANKS-1:0] open_q;
  logic                 err_q;

  logic is_act, is_rd, is_wr;
  logic is_pre, is_ref;
  logic legal, act_go, ref_go;
  logic faw_ok;

  logic [NUM_BANKS-1:0] sel;
  logic [NUM_BANKS-1:0] eff_idle;
  logic [NUM_BANKS-1:0] eff_actv;
  logic [NUM_BANKS-1:0] act_hit;
  logic [NUM_BANKS-1:0] rd_hit;
  logic [NUM_BANKS-1:0] wr_hit;
  logic [NUM_BANKS-1:0] pre_hit;
  logic [NUM_BANKS-1:0] pre_load;

  function automatic logic [CNT_W-1:0] tick(
    input logic [CNT_W-1:0] v,
    input logic             ld,
    input logic [CNT_W-1:0] lv
  );
    if (ld) return lv;
    if (v != '0) return v - CNT_W'(1);
    return v;
  endfunction

  assign is_act = cmd_valid && cmd == C_ACT;
  assign is_rd  = cmd_valid && cmd == C_RD;
  assign is_wr  = cmd_valid && cmd == C_WR;
  assign is_pre = cmd_valid && cmd == C_PRE;
  assign is_ref = cmd_valid && cmd == C_REF;

  always_comb begin
    sel = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      sel[b] = (cmd_bank == BANK_W'(b));
  end

  // Legality is judged only against registered flags.
  always_comb begin
    legal = 1'b1;
    unique case (1'b1)
      is_act:         legal = act_ok[cmd_bank];
      is_rd || is_wr: legal = rdwr_ok[cmd_bank];
      is_pre:         legal = pre_ok[cmd_bank];
      is_ref:         legal = ref_ok;
      default:        legal = 1'b1;
    endcase
  end

  assign act_go  = is_act && legal;
  assign ref_go  = is_ref && legal;
  assign act_hit = sel & {NUM_BANKS{act_go}};
  assign rd_hit  = sel & {NUM_BANKS{is_rd && legal}};
  assign wr_hit  = sel & {NUM_BANKS{is_wr && legal}};
  assign pre_hit = sel & {NUM_BANKS{is_pre && legal}};

  // PRE to an idle bank is a no-op and loads nothing.
  assign pre_load = pre_hit & eff_actv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++)
        st_q[b] <= S_IDLE;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++)
        st_q[b] <= st_d[b];
    end
  end

  // A counter reaching zero counts as expired in that
  // same cycle, so transitions may merge with a command.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      st_d[b] = st_q[b];
      unique case (st_q[b])
        S_IDLE:
          if (act_hit[b]) st_d[b] = S_ACTG;
        S_ACTG:
          if (rcd_q[b] == '0)
            st_d[b] = pre_hit[b] ? S_PRCH : S_ACTV;
        S_ACTV:
          if (pre_hit[b]) st_d[b] = S_PRCH;
        S_PRCH:
          if (rp_q[b] == '0)
            st_d[b] = act_hit[b] ? S_ACTG : S_IDLE;
        default: st_d[b] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    eff_idle = '0;
    eff_actv = '0;
    act_ok   = '0;
    rdwr_ok  = '0;
    pre_ok   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      eff_idle[b] = st_q[b] == S_IDLE ||
                    (st_q[b] == S_PRCH && rp_q[b] == '0);
      eff_actv[b] = st_q[b] == S_ACTV ||
                    (st_q[b] == S_ACTG && rcd_q[b] == '0);
      act_ok[b]   = eff_idle[b] && rc_q[b] == '0 &&
                    rrd_q == '0 && rfc_q == '0 && faw_ok;
      rdwr_ok[b]  = eff_actv[b];
      pre_ok[b]   = (eff_actv[b] && ras_q[b] == '0 &&
                     wr_q[b] == '0 && rtp_q[b] == '0) ||
                    eff_idle[b];
    end
    ref_ok = (&eff_idle) && rfc_q == '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        rcd_q[b] <= '0;
        rp_q[b]  <= '0;
        ras_q[b] <= '0;
        rc_q[b]  <= '0;
        wr_q[b]  <= '0;
        rtp_q[b] <= '0;
        row_q[b] <= '0;
      end
      open_q <= '0;
      rrd_q  <= '0;
      rfc_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        rcd_q[b] <= tick(rcd_q[b], act_hit[b], L_RCD);
        ras_q[b] <= tick(ras_q[b], act_hit[b], L_RAS);
        rc_q[b]  <= tick(rc_q[b], act_hit[b], L_RC);
        rp_q[b]  <= tick(rp_q[b], pre_load[b], L_RP);
        wr_q[b]  <= tick(wr_q[b], wr_hit[b], L_WR);
        rtp_q[b] <= tick(rtp_q[b], rd_hit[b], L_RTP);
        if (act_hit[b]) row_q[b] <= cmd_row;
      end
      open_q <= (open_q | act_hit) & ~pre_load;
      rrd_q  <= tick(rrd_q, act_go, L_RRD);
      rfc_q  <= tick(rfc_q, ref_go, L_RFC);
      err_q  <= ~legal;
    end
  end

`ifdef DDR_TRACK_FAW_EN
  localparam logic [CNT_W-1:0] L_FAW = CNT_W'(T_FAW - 1);

  logic [CNT_W-1:0] faw_q [4];
  logic [1:0]       faw_ptr_q;

  // The slot at the pointer holds the oldest of the last
  // four ACTs; it must have aged out before a new ACT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      faw_ptr_q <= '0;
      for (int i = 0; i < 4; i++)
        faw_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        faw_q[i] <= tick(faw_q[i],
                         act_go && faw_ptr_q == 2'(i),
                         L_FAW);
      if (act_go) faw_ptr_q <= faw_ptr_q + 2'd1;
    end
  end

  assign faw_ok = (faw_q[faw_ptr_q] == '0);
`else
  assign faw_ok = 1'b1;
`endif

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_row
    assign open_row[g*ROW_W +: ROW_W] = row_q[g];
  end

  assign bank_open = open_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_ddr_bank_timing_tracker.sv
// Bench for ddr_bank_timing_tracker: directed commands, queued
// expectations checked by an independent negedge monitor.
module tb_ddr_bank_timing_tracker;

  localparam int NB = 8;
  localparam int RW = 14;
  localparam int BW = 3;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [3:0]    cmd = NOP;
  logic [BW-1:0] cmd_bank = '0;
  logic [RW-1:0] cmd_row = '0;
  logic [NB-1:0] act_ok;
  logic [NB-1:0] rdwr_ok;
  logic [NB-1:0] pre_ok;
  logic          ref_ok;
  logic [NB-1:0] bank_open;
  logic [NB*RW-1:0] open_row;
  logic          cmd_err;

  ddr_bank_timing_tracker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_bank  (cmd_bank),
    .cmd_row   (cmd_row),
    .act_ok    (act_ok),
    .rdwr_ok   (rdwr_ok),
    .pre_ok    (pre_ok),
    .ref_ok    (ref_ok),
    .bank_open (bank_open),
    .open_row  (open_row),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {
    K_ACT, K_RDWR, K_PRE, K_ROW,
    K_ACTV, K_RDWRV, K_PREV, K_OPENV,
    K_ROWV, K_REF, K_ERR
  } kind_e;

  typedef struct {
    int           at;
    kind_e        k;
    int           bank;
    logic [127:0] exp;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic exp_at(input int at, input kind_e k,
                        input int bank, input logic [127:0] v);
    exp_t e;
    int i;
    e.at = at;
    e.k = k;
    e.bank = bank;
    e.exp = v;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endtask

  function automatic logic [127:0] observe(input kind_e k,
                                           input int b);
    logic [127:0] r;
    r = '0;
    case (k)
      K_ACT:   r[0] = act_ok[b];
      K_RDWR:  r[0] = rdwr_ok[b];
      K_PRE:   r[0] = pre_ok[b];
      K_ROW:   r[RW-1:0] = open_row[b*RW +: RW];
      K_ACTV:  r[NB-1:0] = act_ok;
      K_RDWRV: r[NB-1:0] = rdwr_ok;
      K_PREV:  r[NB-1:0] = pre_ok;
      K_OPENV: r[NB-1:0] = bank_open;
      K_ROWV:  r[NB*RW-1:0] = open_row;
      K_REF:   r[0] = ref_ok;
      K_ERR:   r[0] = cmd_err;
      default: r = '0;
    endcase
    return r;
  endfunction

  exp_t         m_e;
  kind_e        m_k;
  logic [127:0] m_got;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      m_e = sb.pop_front();
      m_k = m_e.k;
      m_got = observe(m_e.k, m_e.bank);
      n_vec++;
      if (m_e.at != cyc) begin
        n_err++;
        $display("FAIL %s[%0d] missed cycle %0d (now %0d)",
                 m_k.name(), m_e.bank, m_e.at, cyc);
      end else if (m_got !== m_e.exp) begin
        n_err++;
        $display("FAIL %s[%0d] cycle %0d: got %0h, expected %0h",
                 m_k.name(), m_e.bank, cyc, m_got, m_e.exp);
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic issue(input int t, input logic v,
                       input logic [3:0] c, input int b,
                       input logic [RW-1:0] row);
    wait_cyc(t);
    cmd_valid = v;
    cmd = c;
    cmd_bank = BW'(b);
    cmd_row = row;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd = NOP;
    cmd_bank = '0;
    cmd_row = '0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() > 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() > 0) begin
      n_err += sb.size();
      $display("FAIL scoreboard: %0d expectations unchecked",
               sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic exp_reset_state(input int t);
    exp_at(t, K_ACTV, 0, 128'hFF);
    exp_at(t, K_PREV, 0, 128'hFF);
    exp_at(t, K_RDWRV, 0, 128'h0);
    exp_at(t, K_REF, 0, 128'h1);
    exp_at(t, K_OPENV, 0, 128'h0);
    exp_at(t, K_ROWV, 0, 128'h0);
    exp_at(t, K_ERR, 0, 128'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int B;
    logic [127:0] rv;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ACT/RCD/RRD, early PRE rejected, PRE after RAS, RC.
    B = cyc + 2;
    exp_reset_state(B);
    exp_at(B+1, K_RDWR, 2, 128'h0);
    exp_at(B+1, K_ACT, 2, 128'h0);
    exp_at(B+1, K_ACT, 3, 128'h0);
    exp_at(B+1, K_OPENV, 0, 128'h04);
    exp_at(B+1, K_ROW, 2, 128'h1234);
    exp_at(B+1, K_ERR, 0, 128'h0);
    exp_at(B+3, K_OPENV, 0, 128'h04);
    exp_at(B+3, K_ROW, 3, 128'h0);
    exp_at(B+3, K_ERR, 0, 128'h0);
    exp_at(B+9, K_ACT, 3, 128'h0);
    exp_at(B+10, K_ACT, 3, 128'h1);
    exp_at(B+14, K_RDWR, 2, 128'h0);
    exp_at(B+15, K_RDWR, 2, 128'h1);
    exp_at(B+21, K_ERR, 0, 128'h1);
    exp_at(B+21, K_RDWR, 2, 128'h1);
    exp_at(B+21, K_OPENV, 0, 128'h04);
    exp_at(B+22, K_ERR, 0, 128'h0);
    exp_at(B+39, K_PRE, 2, 128'h0);
    exp_at(B+40, K_PRE, 2, 128'h1);
    exp_at(B+41, K_OPENV, 0, 128'h0);
    exp_at(B+41, K_RDWR, 2, 128'h0);
    exp_at(B+41, K_PRE, 2, 128'h0);
    exp_at(B+41, K_ACT, 2, 128'h0);
    exp_at(B+41, K_ERR, 0, 128'h0);
    exp_at(B+54, K_ACT, 2, 128'h0);
    exp_at(B+55, K_ACT, 2, 128'h1);
    exp_at(B+55, K_PRE, 2, 128'h1);
    issue(B, 1'b1, ACT, 2, 14'h1234);
    issue(B+2, 1'b0, ACT, 3, 14'h0777);
    issue(B+20, 1'b1, PRE, 2, '0);
    issue(B+40, 1'b1, PRE, 2, '0);
    drain();

    // WR recovery gates PRE; RD during ACTIVATING rejected.
    do_reset();
    B = cyc + 2;
    exp_reset_state(B);
    exp_at(B+6, K_ERR, 0, 128'h1);
    exp_at(B+7, K_ERR, 0, 128'h0);
    exp_at(B+37, K_PRE, 1, 128'h0);
    exp_at(B+39, K_ERR, 0, 128'h0);
    exp_at(B+39, K_RDWR, 1, 128'h1);
    exp_at(B+40, K_PRE, 1, 128'h0);
    exp_at(B+52, K_PRE, 1, 128'h0);
    exp_at(B+53, K_PRE, 1, 128'h1);
    issue(B, 1'b1, ACT, 1, 14'h0055);
    issue(B+5, 1'b1, RD, 1, '0);
    issue(B+38, 1'b1, WR, 1, '0);
    drain();

    // REF with open bank rejected; REF when idle blocks ACT.
    do_reset();
    B = cyc + 2;
    exp_at(B+20, K_REF, 0, 128'h0);
    exp_at(B+21, K_ERR, 0, 128'h1);
    exp_at(B+21, K_OPENV, 0, 128'h01);
    exp_at(B+21, K_RDWR, 0, 128'h1);
    exp_at(B+21, K_ROW, 0, 128'h0abc);
    exp_at(B+21, K_ACT, 5, 128'h1);
    exp_at(B+22, K_ERR, 0, 128'h0);
    exp_at(B+46, K_ERR, 0, 128'h0);
    exp_at(B+59, K_REF, 0, 128'h0);
    exp_at(B+60, K_REF, 0, 128'h1);
    exp_at(B+99, K_ACTV, 0, 128'hFF);
    exp_at(B+101, K_ACTV, 0, 128'h0);
    exp_at(B+101, K_REF, 0, 128'h0);
    exp_at(B+101, K_ERR, 0, 128'h0);
    exp_at(B+204, K_ACTV, 0, 128'h0);
    exp_at(B+205, K_ACTV, 0, 128'hFF);
    exp_at(B+205, K_REF, 0, 128'h1);
    issue(B, 1'b1, ACT, 0, 14'h0abc);
    issue(B+20, 1'b1, REF, 0, '0);
    issue(B+45, 1'b1, PRE, 0, '0);
    issue(B+100, 1'b1, REF, 0, '0);
    drain();

    // Four ACTs spaced by RRD; fifth limited by FAW if built.
    do_reset();
    B = cyc + 2;
    exp_at(B+31, K_ERR, 0, 128'h0);
    exp_at(B+31, K_OPENV, 0, 128'h0F);
    exp_at(B+39, K_ACT, 4, 128'h0);
`ifdef DDR_TRACK_FAW_EN
    exp_at(B+40, K_ACTV, 0, 128'h00);
    exp_at(B+44, K_ACT, 4, 128'h0);
`else
    exp_at(B+40, K_ACTV, 0, 128'hF0);
    exp_at(B+44, K_ACT, 4, 128'h1);
`endif
    exp_at(B+42, K_ERR, 0, 128'h1);
    exp_at(B+43, K_ERR, 0, 128'h0);
    exp_at(B+43, K_OPENV, 0, 128'h0F);
    exp_at(B+45, K_ACTV, 0, 128'hF0);
    issue(B, 1'b1, ACT, 0, 14'h0100);
    issue(B+10, 1'b1, ACT, 1, 14'h0101);
    issue(B+20, 1'b1, ACT, 2, 14'h0102);
    issue(B+30, 1'b1, ACT, 3, 14'h0103);
    issue(B+41, 1'b1, ACT, 0, 14'h0200);
    drain();

    // Asynchronous reset while bank 2 is activating.
    do_reset();
    B = cyc + 2;
    rv = '0;
    rv[2*RW +: RW] = 14'h2222;
    exp_at(B+1, K_OPENV, 0, 128'h04);
    exp_at(B+1, K_ROWV, 0, rv);
    exp_at(B+4, K_ERR, 0, 128'h1);
    exp_reset_state(B+5);
    issue(B, 1'b1, ACT, 2, 14'h2222);
    issue(B+3, 1'b1, RD, 2, '0);
    wait_cyc(B+4);
    cmd_valid = 1'b1;
    cmd = RD;
    cmd_bank = 3'd2;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd = NOP;
    cmd_bank = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
